// File: rtl/cache_pkg.sv
// Shared types and helpers for the 2-way set-associative cache array.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package cache_pkg;

    // Invalidation sweep walks every set once; RUN means the array is usable.
    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } sweep_state_t;

    // One bit names a way; lru stores the way to evict next.
    typedef logic way_sel_t;
    localparam way_sel_t WAY0 = 1'b0;
    localparam way_sel_t WAY1 = 1'b1;

    // Extract an address field (tag, index or word) given its lsb and width.
    // A zero-width field returns 0, which keeps single-word lines working.
    function automatic logic [63:0] addr_field(input logic [63:0] a,
                                               input int lsb,
                                               input int width);
        logic [63:0] mask;
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (a >> lsb) & mask;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: tag/valid/dirty per set plus the line data words.
// Latency: lookup combinational; tag/flag/data updates take effect at the next clk edge.
// Backpressure: none; the parent gates every update.
// Ports: idx/word/tag address the lookup, match/rdata/valid/dirty/tag_q report it;
//        be/wdata write bytes of the addressed word, fill_tag installs tag (v=1,d=0),
//        set_dirty marks the set dirty, clr/clr_idx invalidate one set for the sweep.
module cache_way
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 256,
    parameter int TAG_W      = 20,
    localparam int IDX_W     = $clog2(SETS),
    localparam int WW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
    localparam int NB        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      idx,
    input  logic [WW-1:0]         word,
    input  logic [TAG_W-1:0]      tag,
    output logic                  match,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_W-1:0]      tag_q,
    input  logic [NB-1:0]         be,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  fill_tag,
    input  logic                  set_dirty,
    input  logic                  clr,
    input  logic [IDX_W-1:0]      clr_idx
);

    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic                  v_mem    [SETS];
    logic                  d_mem    [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS][LINE_WORDS];

    assign valid = v_mem[idx];
    assign dirty = d_mem[idx];
    assign tag_q = tag_mem[idx];
    assign rdata = data_mem[idx][word];
    assign match = v_mem[idx] && (tag_mem[idx] == tag);

    // Arrays carry no reset: the sweep is the only thing that clears v/d.
    always_ff @(posedge clk) begin
        if (clr) begin
            v_mem[clr_idx] <= 1'b0;
            d_mem[clr_idx] <= 1'b0;
        end else if (fill_tag) begin
            tag_mem[idx] <= tag;
            v_mem[idx]   <= 1'b1;
            d_mem[idx]   <= 1'b0;
        end else if (set_dirty) begin
            d_mem[idx] <= 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                data_mem[idx][word][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/cachemem_assoc.sv
// 2-way set-associative data/tag array with 1-bit LRU, victim select and invalidation sweep.
// Latency: hit/rdata/victim_* combinational; writes, refills and LRU land on the next clk edge.
// Backpressure: ready=0 during the sweep; all outputs read 0 and every update is dropped.
// Ports: en/we/addr/wdata access, allocate/fill_last refill beats, inv_all flush pulse;
//        rdata/hit lookup result, victim_dirty/victim_tag/victim_rdata eviction info, ready.
module cachemem_assoc
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 256,
    parameter int ADDR_WIDTH = 32,
    localparam int OFF_W     = $clog2(DATA_WIDTH / 8),
    localparam int WORD_W    = $clog2(LINE_WORDS),
    localparam int IDX_W     = $clog2(SETS),
    localparam int TAG_W     = ADDR_WIDTH - IDX_W - WORD_W - OFF_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic                    allocate,
    input  logic                    fill_last,
    input  logic                    inv_all,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    hit,
    output logic                    victim_dirty,
    output logic [TAG_W-1:0]        victim_tag,
    output logic [DATA_WIDTH-1:0]   victim_rdata,
    output logic                    ready
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int WW = (LINE_WORDS > 1) ? WORD_W : 1;

    // Address split: tag | index | word | byte offset.
    logic [63:0]      addr64, word_f, idx_f, tag_f;
    logic [WW-1:0]    word;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_bits;

    assign addr64 = 64'(addr);
    assign word_f = addr_field(addr64, OFF_W, WORD_W);
    assign idx_f  = addr_field(addr64, OFF_W + WORD_W, IDX_W);
    assign tag_f  = addr_field(addr64, OFF_W + WORD_W + IDX_W, TAG_W);
    assign word   = word_f[WW-1:0];
    assign idx    = idx_f[IDX_W-1:0];
    assign tag    = tag_f[TAG_W-1:0];
    assign unused_bits = ^{word_f[63:WW], idx_f[63:IDX_W], tag_f[63:TAG_W]};

    // Sweep FSM
    sweep_state_t     state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sweep_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (inv_all) begin
            state_d = SWEEP;
            cnt_d   = '0;
        end else if (state_q == SWEEP) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(SETS - 1)) begin
                state_d = RUN;
            end
        end
    end

    assign ready     = (state_q == RUN);
    assign sweep_clr = (state_q == SWEEP);

    // Ways
    logic [1:0]            match, valid, dirty, fill_tag, set_dirty;
    logic [DATA_WIDTH-1:0] way_rd [2];
    logic [TAG_W-1:0]      way_tag[2];
    logic [NB-1:0]         way_be [2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .DATA_WIDTH(DATA_WIDTH),
            .LINE_WORDS(LINE_WORDS),
            .SETS      (SETS),
            .TAG_W     (TAG_W)
        ) u_way (
            .clk      (clk),
            .idx      (idx),
            .word     (word),
            .tag      (tag),
            .match    (match[w]),
            .rdata    (way_rd[w]),
            .valid    (valid[w]),
            .dirty    (dirty[w]),
            .tag_q    (way_tag[w]),
            .be       (way_be[w]),
            .wdata    (wdata),
            .fill_tag (fill_tag[w]),
            .set_dirty(set_dirty[w]),
            .clr      (sweep_clr),
            .clr_idx  (cnt_q)
        );
    end

    // Lookup, victim selection and update control
    way_sel_t lru_mem [SETS];
    way_sel_t hit_way, vict_live, vict_way, vict_q;
    logic     fill_active, accept, do_alloc, do_hit;

    assign hit       = en && ready && (|match);
    assign hit_way   = match[1] ? WAY1 : WAY0;
    assign vict_live = !valid[0] ? WAY0 : (!valid[1] ? WAY1 : lru_mem[idx]);
    // A refill keeps using the way chosen on its first beat even if LRU moves.
    assign vict_way  = fill_active ? vict_q : vict_live;

    assign rdata        = hit ? way_rd[hit_way] : '0;
    assign victim_dirty = ready && valid[vict_way] && dirty[vict_way];
    assign victim_tag   = ready ? way_tag[vict_way] : '0;
    assign victim_rdata = ready ? way_rd[vict_way] : '0;

    // inv_all overrides everything; allocate overrides the hit path.
    assign accept   = ready && !inv_all;
    assign do_alloc = accept && allocate;
    assign do_hit   = accept && !allocate && hit;

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_be[w]    = '0;
            fill_tag[w]  = 1'b0;
            set_dirty[w] = 1'b0;
        end
        if (do_alloc) begin
            way_be[vict_way]   = we;
            fill_tag[vict_way] = fill_last;
        end else if (do_hit && (|we)) begin
            way_be[hit_way]    = we;
            set_dirty[hit_way] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_active <= 1'b0;
            vict_q      <= WAY0;
        end else if (inv_all) begin
            fill_active <= 1'b0;
        end else if (do_alloc) begin
            fill_active <= !fill_last;
            vict_q      <= vict_way;
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_clr) begin
            lru_mem[cnt_q] <= WAY0;
        end else if (do_alloc && fill_last) begin
            lru_mem[idx] <= ~vict_way;
        end else if (do_hit) begin
            lru_mem[idx] <= ~hit_way;
        end
    end

endmodule

// File: tb/tb_cachemem_assoc.sv
// Scoreboard bench for cachemem_assoc with default parameters (32-bit words, 4-word lines, 256 sets).
// Stimulus pushes expected outputs on probe cycles; a negedge monitor pops and compares.
module tb_cachemem_assoc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  we;
    logic        allocate, fill_last, inv_all;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, victim_rdata;
    logic        hit, victim_dirty, ready;
    logic [19:0] victim_tag;
    logic        probe;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic [31:0] rdata;
        logic        rdy;
        logic        chk_vd;
        logic        vd;
        logic        chk_vt;
        logic [19:0] vt;
        logic [31:0] vr;
    } exp_t;

    exp_t exp_q[$];

    cachemem_assoc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .we          (we),
        .allocate    (allocate),
        .fill_last   (fill_last),
        .inv_all     (inv_all),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .hit         (hit),
        .victim_dirty(victim_dirty),
        .victim_tag  (victim_tag),
        .victim_rdata(victim_rdata),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest expectation on every probe cycle.
    always @(negedge clk) begin
        if (probe) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: probe with no expectation queued");
            end else begin
                exp_t e;
                logic bad;
                e = exp_q.pop_front();
                bad = (hit !== e.hit) || (rdata !== e.rdata) || (ready !== e.rdy)
                   || (e.chk_vd && (victim_dirty !== e.vd))
                   || (e.chk_vt && ((victim_tag !== e.vt) || (victim_rdata !== e.vr)));
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s: got hit=%0b rdata=%h ready=%0b vdirty=%0b vtag=%h vrdata=%h; want hit=%0b rdata=%h ready=%0b vdirty=%0b(chk %0b) vtag=%h vrdata=%h(chk %0b)",
                             e.name, hit, rdata, ready, victim_dirty, victim_tag, victim_rdata,
                             e.hit, e.rdata, e.rdy, e.vd, e.chk_vd, e.vt, e.vr, e.chk_vt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        en = 1'b0; we = '0; allocate = 1'b0; fill_last = 1'b0; inv_all = 1'b0; probe = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic h, input logic [31:0] rd, input logic r,
                              input logic cvd, input logic vd, input logic cvt,
                              input logic [19:0] vt, input logic [31:0] vr);
        exp_t e;
        e.name = nm; e.hit = h; e.rdata = rd; e.rdy = r;
        e.chk_vd = cvd; e.vd = vd; e.chk_vt = cvt; e.vt = vt; e.vr = vr;
        exp_q.push_back(e);
        probe = 1'b1;
    endtask

    // Read access (en=1, no write) with expected hit/rdata.
    task automatic look(input string nm, input logic [31:0] a, input logic h,
                        input logic [31:0] rd, input logic r);
        en = 1'b1; addr = a;
        expect_out(nm, h, rd, r, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    // Victim-only probe (en=0 so LRU is not disturbed).
    task automatic vic(input string nm, input logic [31:0] a, input logic vd,
                       input logic cvt, input logic [19:0] vt, input logic [31:0] vr);
        en = 1'b0; addr = a;
        expect_out(nm, 1'b0, '0, 1'b1, 1'b1, vd, cvt, vt, vr);
        step();
    endtask

    task automatic wr(input string nm, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input logic [31:0] old);
        en = 1'b1; we = w; addr = a; wdata = d;
        expect_out(nm, 1'b1, old, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
    endtask

    // Refill beats first..last of a 4-word line; beat 3 carries fill_last.
    task automatic refill(input logic [31:0] base, input logic [31:0] d0,
                          input int first, input int last, input logic probe_last);
        for (int i = first; i <= last; i++) begin
            allocate = 1'b1; we = 4'hF; fill_last = (i == 3);
            addr = base + 32'(4 * i); wdata = d0 + 32'(i);
            if (probe_last && i == 3) begin
                en = 1'b1;
                expect_out("hit_low_on_fill_last", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
            end
            step();
        end
    endtask

    task automatic wait_ready(input string nm, input int already);
        int cnt;
        cnt = already;
        while (!ready && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        n_tests++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL %s: ready rose after %0d cycles, want 256", nm, cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; we = '0; allocate = 1'b0; fill_last = 1'b0; inv_all = 1'b0;
        addr = '0; wdata = '0; probe = 1'b0;
        step();
        // Reset state: everything reads 0, even with an access presented.
        en = 1'b1; addr = 32'h1000;
        expect_out("reset_outputs", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
        step();
        rst_n = 1'b1;
        look("access_during_sweep", 32'h1000, 1'b0, '0, 1'b0);
        wait_ready("post_reset_sweep_len", 1);

        // Refill 0x1000 into way 0 (both invalid), check hit blocked until after fill_last.
        refill(32'h1000, 32'hA0, 0, 2, 1'b0);
        look("miss_mid_refill", 32'h1000, 1'b0, '0, 1'b1);
        refill(32'h1000, 32'hA0, 3, 3, 1'b1);
        look("read_1008", 32'h1008, 1'b1, 32'hA2, 1'b1);

        // Byte-strobe write hit, then read back.
        wr("write_hit_1004", 32'h1004, 4'b0010, 32'h0000_5500, 32'hA1);
        look("read_1004_merged", 32'h1004, 1'b1, 32'h0000_55A1, 1'b1);

        // Second line goes to way 1 (still invalid); make way 0 MRU.
        refill(32'h0002_1000, 32'hC0, 0, 3, 1'b0);
        look("read_1004_mru", 32'h1004, 1'b1, 32'h0000_55A1, 1'b1);
        vic("victim_way1_clean", 32'h0004_1000, 1'b0, 1'b1, 20'h21, 32'hC0);
        wr("write_hit_21004", 32'h0002_1004, 4'hF, 32'hDEAD_BEEF, 32'hC1);
        vic("victim_way0_dirty", 32'h0004_1000, 1'b1, 1'b1, 20'h1, 32'hA0);

        // Read way 0, miss a third tag: way 1 evicted, latched across a mid-refill hit.
        look("read_1000", 32'h1000, 1'b1, 32'hA0, 1'b1);
        refill(32'h0004_1000, 32'hB0, 0, 0, 1'b0);
        look("old_way1_hit_mid_refill", 32'h0002_100C, 1'b1, 32'hC3, 1'b1);
        vic("victim_latched_way1", 32'h0004_1000, 1'b1, 1'b1, 20'h21, 32'hB0);
        refill(32'h0004_1000, 32'hB0, 1, 3, 1'b0);
        look("read_41008", 32'h0004_1008, 1'b1, 32'hB2, 1'b1);
        look("way0_still_hits", 32'h1004, 1'b1, 32'h0000_55A1, 1'b1);
        look("evicted_21000_miss", 32'h0002_1000, 1'b0, '0, 1'b1);

        // Flush with dirty lines present.
        inv_all = 1'b1;
        step();
        en = 1'b1; addr = 32'h1000;
        expect_out("inv_outputs_zero", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
        step();
        wait_ready("inv_sweep_len", 1);
        look("post_inv_miss_1000", 32'h1000, 1'b0, '0, 1'b1);
        look("post_inv_miss_41000", 32'h0004_1000, 1'b0, '0, 1'b1);
        vic("post_inv_victim_clean", 32'h1000, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of a refill.
        refill(32'h3000, 32'hD0, 0, 1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("mid_refill_reset_sweep_len", 0);
        look("abandoned_refill_miss", 32'h3000, 1'b0, '0, 1'b1);
        refill(32'h3000, 32'hD0, 0, 3, 1'b0);
        look("fresh_refill_300C", 32'h300C, 1'b1, 32'hD3, 1'b1);
        look("fresh_refill_3004", 32'h3004, 1'b1, 32'hD1, 1'b1);
        vic("fresh_set_victim_clean", 32'h5000, 1'b0, 1'b0, '0, '0);

        // Last set index (255).
        refill(32'h7FF0, 32'hE0, 0, 3, 1'b0);
        look("last_set_hit", 32'h7FF8, 1'b1, 32'hE2, 1'b1);

        step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cachemem_assoc.md
Name: cachemem_assoc

Overview:
- Parametrised 2-way set-associative cache data/tag array with multi-word lines, byte-strobe writes, 1-bit LRU per set and a victim-selection path.
- Lookup is combinational and same-cycle; array updates happen on the clock edge.
- A hardware invalidation sweep runs after reset and on request, so reset never clears the arrays directly.
- Sits between the pipeline's memory stage and the cache controller FSM. The controller drives refill and write-back; this block only stores, selects and reports.

Parameters:
- DATA_WIDTH, 32, word width in bits; a multiple of 8.
- LINE_WORDS, 4, words per line; a power of 2, at least 1.
- SETS, 256, number of sets; a power of 2, at least 2.
- ADDR_WIDTH, 32, byte address width.
- Derived, not overridable:
  - OFF_W = log2(DATA_WIDTH/8)
  - WORD_W = log2(LINE_WORDS)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_WIDTH - IDX_W - WORD_W - OFF_W

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  access valid this cycle
- we  in  DATA_WIDTH/8  byte write strobes; all zero means read
- allocate  in  1  refill beat: write wdata into the latched victim way
- fill_last  in  1  qualifies allocate: final beat of the line
- inv_all  in  1  one-cycle pulse: start the invalidation sweep
- addr  in  ADDR_WIDTH  byte address
- wdata  in  DATA_WIDTH  write/refill data
- rdata  out  DATA_WIDTH  hit-way word at addr
- hit  out  1  tag match in a valid way
- victim_dirty  out  1  victim way valid and dirty
- victim_tag  out  TAG_W  victim way stored tag
- victim_rdata  out  DATA_WIDTH  victim way word at addr word offset
- ready  out  1  sweep finished, array usable

Behaviour:
- Address split, MSB to LSB: tag | index | word | byte offset.
- Reset (asynchronous, active-low):
  - Clears only the control registers: ready=0, sweep counter=0, victim latch cleared, fill_active=0.
  - The sweep starts on the first clock after rst_n deasserts.
  - Reset during a refill abandons that refill. The line's valid bit is never set and the sweep clears it anyway.
- Sweep:
  - States are SWEEP and RUN.
  - SWEEP clears v, d and lru for one set per cycle, index 0 up to SETS-1.
  - After SETS cycles: state goes to RUN and ready=1.
  - inv_all in RUN enters SWEEP the next cycle, drops ready and discards dirty data. Write-back before flushing is the controller's job.
  - inv_all in SWEEP restarts the counter at 0.
  - Data arrays are not cleared.
- While ready=0, all outputs read 0 and every write, allocate and LRU update is ignored.
- Lookup (combinational):
  - hit = en & ready & (way0 match | way1 match), where a way matches when it is valid and its tag equals the address tag.
  - rdata comes from the matching way; 0 when there is no hit.
  - Both ways matching is illegal and must never arise.
- Victim select (combinational; latched at the first allocate beat):
  - Way 0 if it is invalid.
  - Otherwise way 1 if it is invalid.
  - Otherwise the way indicated by lru[index].
- Write hit (en & hit & |we):
  - Writes the strobed bytes at the next edge and sets d.
  - lru[index] points to the other way.
- Read hit: updates LRU the same way; no data change.
- Refill:
  - First allocate beat latches the victim way and sets fill_active. Later beats use the latched way until fill_last.
  - Each beat writes the strobed bytes into the word selected by addr.
  - The fill_last beat writes tag, sets v=1 and d=0, and sets lru to the other way.
  - A single-beat line (LINE_WORDS=1) is legal: allocate and fill_last arrive together.
  - hit stays 0 for the refilled line until the edge after fill_last.
- Simultaneous events:
  - allocate takes priority over the hit path; the write-hit and LRU updates are suppressed that cycle.
  - inv_all beats everything.
- victim_* outputs reflect the latched way while fill_active, otherwise the live selection.

Decomposition:
- Package cache_pkg holds:
  - an index/tag/word split helper function
  - the sweep state enum {SWEEP, RUN}
  - a way-select typedef
- One sub-module, cache_way: a single way's tag, valid, dirty and data arrays, with lookup and write ports.
- The top module instantiates two cache_way and owns the LRU, victim latch and sweep FSM.

Test Plan:
- Reset, then wait: ready=0 for exactly 256 cycles after rst_n rises, then 1; any access before that gives hit=0.
- Refill 0x0000_1000 over 4 beats with wdata 0xA0..0xA3, then read 0x1008: hit=1, rdata=0xA2, victim for the next miss in that set is way 1.
- Write we=4'b0010, wdata=0x0000_5500 to 0x1004 (hit): rdata=0x0000_55A1; a miss to 0x0004_1000 (same set, both ways full, way 0 MRU) gives victim_dirty per LRU way and victim_tag of that way.
- Fill both ways of set 0, read way 0, miss a third tag: way 1 is evicted and way 0 keeps hitting.
- inv_all with dirty lines present: ready falls next cycle, returns after 256 cycles, all lookups miss and victim_dirty=0.
- Assert rst_n=0 mid-refill after beat 2: after the sweep the address misses, and a fresh refill behaves normally.
